// File: rtl/width_conv_fifo_pkg.sv
// Shared definitions for width-converting NoC interface blocks: conversion
// mode, width/ratio derivation and saturating statistics counter helper.
package width_conv_fifo_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_EXPAND = 2'd1,
        MODE_SHRINK = 2'd2
    } conv_mode_e;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic int unsigned wide_width(input int unsigned in_w, input int unsigned out_w);
        return (in_w > out_w) ? in_w : out_w;
    endfunction

    function automatic int unsigned conv_ratio(input int unsigned in_w, input int unsigned out_w);
        return (in_w > out_w) ? (in_w / out_w) : (out_w / in_w);
    endfunction

    function automatic conv_mode_e conv_mode(input int unsigned in_w, input int unsigned out_w);
        return (out_w > in_w) ? MODE_EXPAND : ((in_w > out_w) ? MODE_SHRINK : MODE_PASS);
    endfunction

    // Index width for a counter over n states; never zero so ratio 1 still builds.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? (v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// WIDTH x 2**ADDR_BITS storage with one write port and a registered read port;
// a same-address write is forwarded so a read of an empty FIFO sees the new word.
module sync_fifo_mem
    import width_conv_fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Storage array write port; contents need no reset since pointers gate validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data selection with write-through for the empty case.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= {WIDTH{1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/width_conv_fifo.sv
// Width-converting FIFO: packs narrow input words (EXPAND), splits wide stored
// words into output slices (SHRINK) or passes through, with statistics counters.
module width_conv_fifo
    import width_conv_fifo_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  d_a,
    input  logic                 vld_a,
    output logic                 rdy_a,
    output logic [OUT_WIDTH-1:0] d_b,
    output logic                 vld_b,
    input  logic                 rdy_b,
    input  logic                 is_done_mode_user,
    output logic [31:0]          full_cnt,
    output logic [31:0]          empty_cnt,
    output logic [31:0]          read_cnt,
    output logic [ADDR_BITS:0]   occupancy
);

    localparam int         WIDE      = int'(wide_width(IN_WIDTH, OUT_WIDTH));
    localparam int         RATIO     = int'(conv_ratio(IN_WIDTH, OUT_WIDTH));
    localparam conv_mode_e MODE      = conv_mode(IN_WIDTH, OUT_WIDTH);
    localparam int         IN_RATIO  = (MODE == MODE_EXPAND) ? RATIO : 1;
    localparam int         OUT_RATIO = (MODE == MODE_SHRINK) ? RATIO : 1;
    localparam int         PW        = int'(idx_bits(IN_RATIO));
    localparam int         SW        = int'(idx_bits(OUT_RATIO));

    localparam logic [PW-1:0]        PACK_LAST  = PW'(IN_RATIO - 1);
    localparam logic [PW-1:0]        PACK_ONE   = PW'(1);
    localparam logic [SW-1:0]        SLICE_LAST = SW'(OUT_RATIO - 1);
    localparam logic [SW-1:0]        SLICE_ONE  = SW'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   OCC_ONE    = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   OCC_ZERO   = {(ADDR_BITS + 1){1'b0}};
    localparam logic [ADDR_BITS:0]   OCC_FULL   = {1'b1, {ADDR_BITS{1'b0}}};

    logic [PW-1:0]        pack_cnt_q, pack_cnt_d;
    logic [WIDE-1:0]      pack_q, pack_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   occ_q, occ_d;
    logic                 out_vld_q, out_vld_d;
    logic [SW-1:0]        slice_q, slice_d;
    logic [31:0]          full_cnt_q, full_cnt_d, empty_cnt_q, empty_cnt_d, read_cnt_q, read_cnt_d;

    logic                 rdy_a_s, acc_a_s, xfer_b_s, wr_en_s, rd_en_s, load_s;
    logic [WIDE-1:0]      wr_data_s, rd_data_s;
    logic [OUT_WIDTH-1:0] d_b_s;

    // Input side: merge the incoming word into the packer at the current slot.
    always_comb begin
        rdy_a_s   = (occ_q != OCC_FULL);
        acc_a_s   = vld_a && rdy_a_s;
        wr_data_s = pack_q;
        for (int i = 0; i < IN_RATIO; i++) begin
            wr_data_s[i*IN_WIDTH +: IN_WIDTH] = (pack_cnt_q == PW'(i)) ? d_a : pack_q[i*IN_WIDTH +: IN_WIDTH];
        end
        wr_en_s    = acc_a_s && (pack_cnt_q == PACK_LAST);
        pack_cnt_d = pack_cnt_q;
        pack_d     = pack_q;
        if (wr_en_s) begin
            pack_cnt_d = {PW{1'b0}};
            pack_d     = {WIDE{1'b0}};
        end else if (acc_a_s) begin
            pack_cnt_d = pack_cnt_q + PACK_ONE;
            pack_d     = wr_data_s;
        end else begin
            pack_cnt_d = pack_cnt_q;
            pack_d     = pack_q;
        end
    end

    // Output stage reloads when idle or on its last slice; a write into an
    // empty store is read in the same cycle through the memory forwarding path.
    always_comb begin
        xfer_b_s  = out_vld_q && rdy_b;
        load_s    = !out_vld_q || (xfer_b_s && (slice_q == SLICE_LAST));
        rd_en_s   = load_s && ((occ_q != OCC_ZERO) || wr_en_s);
        out_vld_d = out_vld_q;
        slice_d   = slice_q;
        if (load_s) begin
            out_vld_d = rd_en_s;
            slice_d   = {SW{1'b0}};
        end else if (xfer_b_s) begin
            slice_d = slice_q + SLICE_ONE;
        end else begin
            slice_d = slice_q;
        end
        wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = rd_en_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({wr_en_s, rd_en_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Output slice selection, least-significant slice first.
    always_comb begin
        d_b_s = rd_data_s[OUT_WIDTH-1:0];
        for (int i = 0; i < OUT_RATIO; i++) begin
            d_b_s = (slice_q == SW'(i)) ? rd_data_s[i*OUT_WIDTH +: OUT_WIDTH] : d_b_s;
        end
    end

    // Statistics counters: saturating, frozen while the user done mode is set.
    always_comb begin
        full_cnt_d  = sat_inc(full_cnt_q,  vld_a && !rdy_a_s && !is_done_mode_user);
        empty_cnt_d = sat_inc(empty_cnt_q, rdy_b && !out_vld_q && !is_done_mode_user);
        read_cnt_d  = sat_inc(read_cnt_q,  xfer_b_s && !is_done_mode_user);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pack_cnt_q  <= {PW{1'b0}};
            pack_q      <= {WIDE{1'b0}};
            wr_ptr_q    <= {ADDR_BITS{1'b0}};
            rd_ptr_q    <= {ADDR_BITS{1'b0}};
            occ_q       <= OCC_ZERO;
            out_vld_q   <= 1'b0;
            slice_q     <= {SW{1'b0}};
            full_cnt_q  <= 32'd0;
            empty_cnt_q <= 32'd0;
            read_cnt_q  <= 32'd0;
        end else begin
            pack_cnt_q  <= pack_cnt_d;
            pack_q      <= pack_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_vld_q   <= out_vld_d;
            slice_q     <= slice_d;
            full_cnt_q  <= full_cnt_d;
            empty_cnt_q <= empty_cnt_d;
            read_cnt_q  <= read_cnt_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH     (WIDE),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data_s)
    );

    assign rdy_a     = rdy_a_s;
    assign d_b       = d_b_s;
    assign vld_b     = out_vld_q;
    assign occupancy = occ_q;
    assign full_cnt  = full_cnt_q;
    assign empty_cnt = empty_cnt_q;
    assign read_cnt  = read_cnt_q;

endmodule

// File: tb/tb_width_conv_fifo.sv
// Scoreboard bench for width_conv_fifo: PASS, EXPAND (32->128) and SHRINK
// (128->32) instances, directed vectors with hand-computed expectations.
module tb_width_conv_fifo;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic user = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    logic [31:0]  p_d_a, p_d_b, p_full, p_empty, p_read;
    logic         p_vld_a, p_rdy_a, p_vld_b, p_rdy_b;
    logic [2:0]   p_occ;
    logic [31:0]  e_d_a, e_full, e_empty, e_read;
    logic [127:0] e_d_b;
    logic         e_vld_a, e_rdy_a, e_vld_b, e_rdy_b;
    logic [2:0]   e_occ;
    logic [127:0] s_d_a;
    logic [31:0]  s_d_b, s_full, s_empty, s_read;
    logic         s_vld_a, s_rdy_a, s_vld_b, s_rdy_b;
    logic [2:0]   s_occ;

    logic [127:0] p_q[$];
    logic [127:0] e_q[$];
    logic [127:0] s_q[$];
    int   p_last, s_last, p_gaps, s_gaps;
    bit   p_seen, s_seen, p_stall;
    logic [31:0] p_hold;

    width_conv_fifo #(.IN_WIDTH(32), .OUT_WIDTH(32), .ADDR_BITS(2)) u_pass (
        .clk(clk), .reset(reset), .d_a(p_d_a), .vld_a(p_vld_a), .rdy_a(p_rdy_a),
        .d_b(p_d_b), .vld_b(p_vld_b), .rdy_b(p_rdy_b), .is_done_mode_user(user),
        .full_cnt(p_full), .empty_cnt(p_empty), .read_cnt(p_read), .occupancy(p_occ));

    width_conv_fifo #(.IN_WIDTH(32), .OUT_WIDTH(128), .ADDR_BITS(2)) u_exp (
        .clk(clk), .reset(reset), .d_a(e_d_a), .vld_a(e_vld_a), .rdy_a(e_rdy_a),
        .d_b(e_d_b), .vld_b(e_vld_b), .rdy_b(e_rdy_b), .is_done_mode_user(user),
        .full_cnt(e_full), .empty_cnt(e_empty), .read_cnt(e_read), .occupancy(e_occ));

    width_conv_fifo #(.IN_WIDTH(128), .OUT_WIDTH(32), .ADDR_BITS(2)) u_shr (
        .clk(clk), .reset(reset), .d_a(s_d_a), .vld_a(s_vld_a), .rdy_a(s_rdy_a),
        .d_b(s_d_b), .vld_b(s_vld_b), .rdy_b(s_rdy_b), .is_done_mode_user(user),
        .full_cnt(s_full), .empty_cnt(s_empty), .read_cnt(s_read), .occupancy(s_occ));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got output %0h expected none", name, act);
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (reset) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) chk("pass_hold", {p_vld_b, p_d_b}, {1'b1, p_hold});
            p_stall = p_vld_b && !p_rdy_b;
            p_hold  = p_d_b;
            if (p_vld_b && p_rdy_b) begin
                if (p_q.size() == 0) unexpected("pass_extra", p_d_b);
                else chk("pass_data", p_d_b, p_q.pop_front());
                if (p_seen && (p_last != cyc - 1)) p_gaps++;
                p_seen = 1'b1;
                p_last = cyc;
            end
            if (e_vld_b && e_rdy_b) begin
                if (e_q.size() == 0) unexpected("exp_extra", e_d_b);
                else chk("exp_data", e_d_b, e_q.pop_front());
            end
            if (s_vld_b && s_rdy_b) begin
                if (s_q.size() == 0) unexpected("shr_extra", s_d_b);
                else chk("shr_data", s_d_b, s_q.pop_front());
                if (s_seen && (s_last != cyc - 1)) s_gaps++;
                s_seen = 1'b1;
                s_last = cyc;
            end
        end
    end

    // All tasks below are entered and left just after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        p_vld_a = 1'b0; e_vld_a = 1'b0; s_vld_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        p_q.delete(); e_q.delete(); s_q.delete();
        p_seen = 1'b0; s_seen = 1'b0; p_gaps = 0; s_gaps = 0;
        reset = 1'b0;
    endtask

    task automatic send_p(input logic [31:0] w);
        bit ok = 1'b0;
        p_d_a = w; p_vld_a = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk); ok = p_rdy_a;
            @(posedge clk);
        end
        if (!ok) chk("pass_send_timeout", 128'd0, 128'd1);
        #1 p_vld_a = 1'b0;
    endtask

    task automatic send_e(input logic [31:0] w);
        bit ok = 1'b0;
        e_d_a = w; e_vld_a = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk); ok = e_rdy_a;
            @(posedge clk);
        end
        if (!ok) chk("exp_send_timeout", 128'd0, 128'd1);
        #1 e_vld_a = 1'b0;
    endtask

    task automatic send_s(input logic [127:0] w);
        bit ok = 1'b0;
        s_d_a = w; s_vld_a = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk); ok = s_rdy_a;
            @(posedge clk);
        end
        if (!ok) chk("shr_send_timeout", 128'd0, 128'd1);
        #1 s_vld_a = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && (p_q.size() + e_q.size() + s_q.size()) != 0; n++) @(negedge clk);
        chk("drain_pending", 128'(p_q.size() + e_q.size() + s_q.size()), 128'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        p_d_a = 32'd0; e_d_a = 32'd0; s_d_a = 128'd0;
        p_vld_a = 1'b0; e_vld_a = 1'b0; s_vld_a = 1'b0;
        p_rdy_b = 1'b0; e_rdy_b = 1'b0; s_rdy_b = 1'b0;
        p_last = 0; s_last = 0; p_gaps = 0; s_gaps = 0;
        p_seen = 1'b0; s_seen = 1'b0; p_stall = 1'b0; p_hold = 32'd0;

        // Reset state, then empty_cnt counting and freezing.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld_b", {p_vld_b, s_vld_b, e_vld_b}, 128'd0);
        chk("rst_d_b", {p_d_b, s_d_b}, 128'd0);
        chk("rst_occ", {p_occ, e_occ, s_occ}, 128'd0);
        chk("rst_cnts", {p_full, p_empty, p_read}, 128'd0);
        @(posedge clk); #1;
        reset = 1'b0; p_rdy_b = 1'b1;
        @(negedge clk);
        chk("rst_rdy_a", {p_rdy_a, e_rdy_a, s_rdy_a}, 128'h7);
        repeat (7) @(posedge clk);
        #1 user = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("empty_cnt_frozen", p_empty, 32'd7);
        chk("read_cnt_idle", p_read, 32'd0);
        @(posedge clk); #1 user = 1'b0;

        // PASS with ADDR_BITS=2 and a blocked output: 4 stored + 1 in output stage.
        do_reset();
        p_rdy_b = 1'b0;
        w = 32'd100;
        p_d_a = w; p_vld_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bit acc;
            @(negedge clk); acc = p_rdy_a;
            if (acc) p_q.push_back(128'(w));
            @(posedge clk); #1;
            if (acc) w = w + 32'd1;
            p_d_a = w;
        end
        p_vld_a = 1'b0;
        @(negedge clk);
        chk("full_rdy_a", p_rdy_a, 1'b0);
        chk("full_cnt", p_full, 32'd5);
        chk("full_occ", p_occ, 3'd4);
        chk("full_vld_b", p_vld_b, 1'b1);
        @(posedge clk); #1 p_rdy_b = 1'b1;
        wait_drain();
        chk("drain_occ", p_occ, 3'd0);
        chk("drain_read_cnt", p_read, 32'd5);

        // PASS streaming 1..2000 with both sides always ready.
        do_reset();
        p_rdy_b = 1'b1;
        for (int i = 1; i <= 2000; i++) begin
            p_q.push_back(128'(i));
            send_p(32'(i));
        end
        wait_drain();
        chk("stream_gaps", 128'(p_gaps), 128'd0);
        chk("stream_full_cnt", p_full, 32'd0);
        chk("stream_read_cnt", p_read, 32'd2000);

        // EXPAND 32->128: partial pack held, output one cycle after 4th accept.
        do_reset();
        e_rdy_b = 1'b1;
        send_e(32'h1); send_e(32'h2); send_e(32'h3);
        @(negedge clk);
        chk("exp_partial_held", e_vld_b, 1'b0);
        @(posedge clk); #1;
        e_q.push_back(128'h00000004_00000003_00000002_00000001);
        send_e(32'h4);
        @(negedge clk);
        chk("exp_latency", e_vld_b, 1'b1);
        @(posedge clk); #1;
        e_q.push_back(128'hDEAD0008_00000007_C0DE0006_00000005);
        send_e(32'h00000005); send_e(32'hC0DE0006); send_e(32'h00000007); send_e(32'hDEAD0008);
        wait_drain();

        // EXPAND: reset in the middle of a pack discards it.
        do_reset();
        e_rdy_b = 1'b1;
        send_e(32'hAA); send_e(32'hBB);
        do_reset();
        e_q.push_back(128'h00000014_00000013_00000012_00000011);
        send_e(32'h11); send_e(32'h12); send_e(32'h13); send_e(32'h14);
        wait_drain();
        chk("exp_post_reset_reads", e_read, 32'd1);

        // SHRINK 128->32: slices LSB first, back-to-back words without bubbles.
        do_reset();
        s_rdy_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [127:0] sw;
            for (int j = 0; j < 4; j++) begin
                sw[j*32 +: 32] = 32'(k*4 + j + 1);
                s_q.push_back(128'(k*4 + j + 1));
            end
            send_s(sw);
        end
        wait_drain();
        chk("shr_gaps", 128'(s_gaps), 128'd0);
        chk("shr_read_cnt", s_read, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/width_conv_fifo.md
WIDTH_CONV_FIFO -- requirements
Module: width_conv_fifo

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, input data width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, output data width in bits; max(IN_WIDTH,OUT_WIDTH) SHALL be an integer multiple of min(IN_WIDTH,OUT_WIDTH).
REQ-003 SHALL have parameter ADDR_BITS, default 5, storage depth DEPTH = 2**ADDR_BITS entries of WIDE = max(IN_WIDTH,OUT_WIDTH) bits.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports d_a input IN_WIDTH, vld_a input 1, rdy_a output 1: upstream valid/ready channel.
REQ-007 SHALL have ports d_b output OUT_WIDTH, vld_b output 1, rdy_b input 1: downstream valid/ready channel.
REQ-008 SHALL have port is_done_mode_user, input, 1, freezes all statistics counters while high.
REQ-009 SHALL have ports full_cnt, empty_cnt, read_cnt, output, 32 each: statistics counters.
REQ-010 SHALL have port occupancy, output, ADDR_BITS+1, number of WIDE entries in storage.

Function
REQ-011 Transfer occurs on a channel in any cycle where valid and ready are both high; vld_b, once high, SHALL hold with d_b stable until rdy_b.
REQ-012 RATIO = WIDE/min width; mode EXPAND if OUT>IN, SHRINK if IN>OUT, PASS if equal.
REQ-013 EXPAND: packer collects RATIO input words, first-accepted in bits [IN_WIDTH-1:0]; the RATIO-th accepted word SHALL write the packed word into storage the same cycle.
REQ-014 SHRINK: each stored word emitted as RATIO output words, least-significant slice first.
REQ-015 PASS: plain FIFO, one input word per output word.
REQ-016 rdy_a SHALL equal !(occupancy == DEPTH) in all modes; no combinational path from rdy_b to rdy_a.
REQ-017 Output is a registered stage holding one WIDE word plus slice index; it SHALL load from storage whenever empty or when its last slice transfers, with no bubble if storage non-empty.
REQ-018 Latency: word completing a storage write in cycle t into empty FIFO and empty output stage SHALL give vld_b=1 at cycle t+1.
REQ-019 Simultaneous storage write and read SHALL leave occupancy unchanged and be legal at full and at empty.
REQ-020 Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or underflow.
REQ-021 full_cnt SHALL increment in each cycle vld_a && !rdy_a; empty_cnt each cycle rdy_b && !vld_b; read_cnt each output transfer.
REQ-022 Counters SHALL saturate at 32'hFFFF_FFFF and SHALL hold while is_done_mode_user=1.
REQ-023 Partial EXPAND packs SHALL remain held (not emitted) until RATIO words arrive.

Reset
REQ-024 While reset=1: vld_b=0, d_b=0, occupancy=0, pointers=0, packer count and slice index=0, all counters=0; rdy_a=1 in the first cycle after release.
REQ-025 Reset mid-operation SHALL discard all stored, packed and partially emitted data.

Structure
REQ-026 Mode enum (EXPAND/SHRINK/PASS) and a ratio/width-derivation function SHALL live in a shared package used by all NoC-interface blocks.
REQ-027 Storage SHALL be one sub-module sync_fifo_mem (WIDE x DEPTH, registered read); packer/unpacker and counters in the top.

Verification
REQ-028 IN=32,OUT=32, 2000 words 1..2000, vld_a and rdy_b always high -> d_b 1..2000 in order, one per cycle after first, full_cnt=0.
REQ-029 IN=32,OUT=128, input 0x1,0x2,0x3,0x4 -> single d_b 0x00000004_00000003_00000002_00000001 one cycle after 4th accept.
REQ-030 IN=128,OUT=32, input 0x4_3_2_1 packed -> d_b sequence 1,2,3,4 on four consecutive cycles with rdy_b high.
REQ-031 ADDR_BITS=2, PASS, rdy_b=0, 10 cycles vld_a=1 -> 4 stored + 1 in output stage, rdy_a=0, full_cnt=5, occupancy=4.
REQ-032 rdy_b=1, vld_a=0 for 7 cycles then is_done_mode_user=1 for 5 more -> empty_cnt=7 and holds.
REQ-033 EXPAND RATIO=4, accept 2 words, pulse reset, then send 4 words -> output contains only the post-reset 4 words.
